// File: rtl/sr_latch_ctrl.sv
// Shares one external cross-coupled NAND set/reset latch among N_REQ requesters.
// Round-robin grant, timed active-low pulses, synchronized readback and pass/fail ack.
module sr_latch_ctrl #(
    parameter int N_REQ      = 4,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] op,
    output logic [N_REQ-1:0] ack,
    output logic             err,
    output logic             busy,
    output logic             q_state,
    output logic             set_n,
    output logic             clr_n,
    input  logic             latch_q
);

    localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(N_REQ);

    typedef enum logic [2:0] {INIT, IDLE, DRIVE, SETTLE, CHECK, ACK} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [IDX_W-1:0]   win, win_nx;
    logic [IDX_W-1:0]   last_grant, last_nx;
    logic               op_r, op_nx;
    logic               init_r, init_nx;
    logic               err_nx;
    logic               sync1;
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   idx;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found = 1'b0;
        pick  = last_grant;
        idx   = last_grant;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IDX_W'((int'(last_grant) + i) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        win_nx   = win;
        op_nx    = op_r;
        last_nx  = last_grant;
        init_nx  = init_r;
        err_nx   = 1'b0;
        case (state)
            // Power-up clear reuses DRIVE/SETTLE; init_r skips the readback check.
            INIT: begin
                state_nx = DRIVE;
                op_nx    = 1'b0;
                init_nx  = 1'b1;
                cnt_nx   = CNT_W'(PULSE_CYC - 1);
            end
            IDLE: begin
                if (found) begin
                    win_nx = pick;
                    op_nx  = op[pick];
                    if (op[pick] == q_state) begin
                        state_nx = ACK;
                    end else begin
                        state_nx = DRIVE;
                        cnt_nx   = CNT_W'(PULSE_CYC - 1);
                    end
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    state_nx = SETTLE;
                    cnt_nx   = CNT_W'(SETTLE_CYC - 1);
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nx = init_r ? IDLE : CHECK;
                    init_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            CHECK: begin
                err_nx   = (q_state != op_r);
                state_nx = ACK;
            end
            ACK: begin
                last_nx  = win;
                state_nx = IDLE;
            end
            default: state_nx = INIT;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            cnt        <= '0;
            win        <= '0;
            last_grant <= '0;
            op_r       <= 1'b0;
            init_r     <= 1'b0;
            sync1      <= 1'b0;
            q_state    <= 1'b0;
            set_n      <= 1'b1;
            clr_n      <= 1'b1;
            ack        <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            win        <= win_nx;
            last_grant <= last_nx;
            op_r       <= op_nx;
            init_r     <= init_nx;
            sync1      <= latch_q;
            q_state    <= sync1;
            set_n      <= !((state_nx == DRIVE) && op_nx);
            clr_n      <= !((state_nx == DRIVE) && !op_nx);
            ack        <= (state_nx == ACK) ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_nx) : '0;
            err        <= err_nx;
            busy       <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: behavioural NAND latch, vector table, ack scoreboard,
// plus hand sequences for init, round-robin and reset mid-drive.
module tb_sr_latch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] op  = '0;
    logic [3:0] ack;
    logic       err, busy, q_state, set_n, clr_n, latch_q;
    logic       q_model = 1'b1;
    logic       stuck0  = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] ack;
        logic       err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] req;
        logic [3:0] op;
        logic       stuck;
        logic [3:0] ack;
        logic       err;
        int         lat;
        int         slo;
        int         clo;
        logic       q;
    } vec_t;
    vec_t vecs[7];

    sr_latch_ctrl #(.N_REQ(4), .PULSE_CYC(2), .SETTLE_CYC(3)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .ack(ack), .err(err),
        .busy(busy), .q_state(q_state), .set_n(set_n), .clr_n(clr_n),
        .latch_q(latch_q)
    );

    always #5 clk = ~clk;

    // Cross-coupled NAND latch: set_n low forces 1, clr_n low forces 0, else hold.
    always @(set_n or clr_n) begin
        if (set_n === 1'b0) q_model = 1'b1;
        else if (clr_n === 1'b0) q_model = 1'b0;
    end
    assign latch_q = stuck0 ? 1'b0 : q_model;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, expv);
        end
    endtask

    // Monitor: both-low invariant every cycle; each ack pops the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        total++;
        if (set_n === 1'b0 && clr_n === 1'b0) begin
            bad++;
            $display("FAIL both_low set_n=%b clr_n=%b at %0t", set_n, clr_n, $time);
        end
        if (ack !== 4'b0000) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack got=%b want=0000 at %0t", ack, $time);
            end else begin
                e = sb.pop_front();
                total += 2;
                if (ack !== e.ack) begin
                    bad++;
                    $display("FAIL sb_ack got=%b want=%b at %0t", ack, e.ack, $time);
                end
                if (err !== e.err) begin
                    bad++;
                    $display("FAIL sb_err got=%b want=%b at %0t", err, e.err, $time);
                end
            end
        end
    end

    task automatic reset_and_init();
        int n, clo, slo;
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        chk("rst_set_n", set_n, 1);
        chk("rst_clr_n", clr_n, 1);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 1);
        rst = 1'b0;
        n = 0; clo = 0; slo = 0;
        do begin
            @(negedge clk);
            n++;
            if (!clr_n) clo++;
            if (!set_n) slo++;
        end while (busy && n < 20);
        chk("init_busy_fall_cycle", n, 6);
        chk("init_clr_low_cycles", clo, 2);
        chk("init_set_low_cycles", slo, 0);
        chk("init_q_state", q_state, 0);
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int n, slo, clo;
        exp_t e;
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_idle", k), busy, 0);
        e.ack = v.ack;
        e.err = v.err;
        sb.push_back(e);
        stuck0 = v.stuck;
        req = v.req;
        op  = v.op;
        n = 0; slo = 0; clo = 0;
        do begin
            @(negedge clk);
            n++;
            if (!set_n) slo++;
            if (!clr_n) clo++;
        end while (ack == 4'b0000 && n < 30);
        req = '0;
        chk($sformatf("v%0d_latency", k), n, v.lat);
        chk($sformatf("v%0d_set_low", k), slo, v.slo);
        chk($sformatf("v%0d_clr_low", k), clo, v.clo);
        chk($sformatf("v%0d_q_state", k), q_state, v.q);
        stuck0 = 1'b0;
    endtask

    initial begin
        int n, got;
        logic [3:0] rr_exp [5];
        exp_t e;

        //         req      op       stk   ack      err   lat slo clo q
        vecs[0] = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b0, 7, 2, 0, 1'b1};
        vecs[1] = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b0, 1, 0, 0, 1'b1};
        vecs[2] = '{4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 7, 0, 2, 1'b0};
        vecs[3] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1, 0, 0, 1'b0};
        vecs[4] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 7, 2, 0, 1'b0};
        vecs[5] = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b0, 1, 0, 0, 1'b1};
        vecs[6] = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 7, 0, 2, 1'b0};

        reset_and_init();
        for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

        // Round-robin with all requesters held: pointer reset to 0, so order 1,2,3,0,1.
        reset_and_init();
        rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int k = 0; k < 5; k++) begin
            e.ack = rr_exp[k];
            e.err = 1'b0;
            sb.push_back(e);
        end
        op  = 4'b0101;
        req = 4'b1111;
        n = 0; got = 0;
        while (got < 5 && n < 200) begin
            @(negedge clk);
            n++;
            if (ack != 4'b0000) begin
                chk($sformatf("rr_grant%0d", got), ack, rr_exp[got]);
                got++;
            end
        end
        req = '0;
        chk("rr_ack_count", got, 5);

        // Reset during the second DRIVE cycle of a set request.
        repeat (3) @(negedge clk);
        req = 4'b0100;
        op  = 4'b0100;
        repeat (2) @(negedge clk);
        chk("mid_drive_set_low", set_n, 0);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("mid_rst_set_n", set_n, 1);
        chk("mid_rst_clr_n", clr_n, 1);
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_busy", busy, 1);
        reset_and_init();
        repeat (4) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
